branch_predictor: RTL and testbench

//  Parametrised fetch-stage predictor: saturating-counter direction table (BHT) plus tagged branch target table (BTB).

---
 rtl/branch_predictor.sv | 150 +++++++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: saturating-counter BHT plus tagged BTB, with
// optional gshare indexing from a non-speculative global history register.
module branch_predictor #(
    parameter  int XLEN       = 32,
    parameter  int INDEX_BITS = 8,
    parameter  int CTR_BITS   = 2,
    parameter  int GHR_BITS   = 0,
    localparam int GW         = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_busy,
    input  logic [XLEN-1:0] lk_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [GW-1:0]   lk_ghr,
    input  logic            up_valid,
    input  logic [XLEN-1:0] up_pc,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target,
    input  logic [GW-1:0]   up_ghr,
    input  logic            up_mispredict,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispred
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CTR_BITS-1:0] bht_q     [ENTRIES];
    logic                btb_vld_q [ENTRIES];
    logic [TAG_W-1:0]    btb_tag_q [ENTRIES];
    logic [XLEN-1:0]     btb_tgt_q [ENTRIES];

    logic [0:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [GW-1:0]         ghr_q, ghr_d;
    logic [31:0]           stat_upd_q, stat_upd_d;
    logic [31:0]           stat_mis_q, stat_mis_d;

    function automatic logic [INDEX_BITS-1:0] bht_hash(input logic [INDEX_BITS-1:0] pc_idx,
                                                       input logic [GW-1:0] hist);
        if (GHR_BITS > 0) return pc_idx ^ INDEX_BITS'(hist);
        else              return pc_idx;
    endfunction

    // Lookup side
    logic [INDEX_BITS-1:0] lk_bidx, lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;

    assign init_busy = (state_q == ST_INIT);
    assign lk_idx    = lk_pc[INDEX_BITS-1:0];
    assign lk_tag    = lk_pc[XLEN-1:INDEX_BITS];
    assign lk_bidx   = bht_hash(lk_idx, ghr_q);
    assign lk_hit    = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_taken  = !init_busy && bht_q[lk_bidx][CTR_BITS-1] && lk_hit;
    assign pred_target = pred_taken ? btb_tgt_q[lk_idx] : lk_pc + XLEN'(1);
    assign lk_ghr      = ghr_q;

    // Update side
    logic                  upd_en;
    logic [INDEX_BITS-1:0] u_bidx, u_idx;
    logic [CTR_BITS-1:0]   u_ctr, u_ctr_next;

    assign upd_en = (state_q == ST_RUN) && up_valid;
    assign u_idx  = up_pc[INDEX_BITS-1:0];
    assign u_bidx = bht_hash(u_idx, up_ghr);
    assign u_ctr  = bht_q[u_bidx];

    always_comb begin
        u_ctr_next = u_ctr;
        if (up_taken) begin
            if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + CTR_BITS'(1);
        end else begin
            if (u_ctr != '0) u_ctr_next = u_ctr - CTR_BITS'(1);
        end
    end

    logic                  bht_we, btb_we;
    logic [INDEX_BITS-1:0] bht_waddr, btb_waddr;
    logic [CTR_BITS-1:0]   bht_wdata;

    // The init sweep and training share one write port per table.
    always_comb begin
        bht_we    = 1'b0;
        btb_we    = 1'b0;
        bht_waddr = u_bidx;
        btb_waddr = u_idx;
        bht_wdata = u_ctr_next;
        if (init_busy) begin
            bht_we    = 1'b1;
            btb_we    = 1'b1;
            bht_waddr = ptr_q;
            btb_waddr = ptr_q;
            bht_wdata = CTR_INIT;
        end else if (upd_en) begin
            bht_we = 1'b1;
            btb_we = up_taken;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ghr_d      = ghr_q;
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + INDEX_BITS'(1);
            if (ptr_q == '1) state_d = ST_RUN;
        end else if (upd_en) begin
            if (GHR_BITS > 0) ghr_d = GW'({ghr_q, up_taken});
            stat_upd_d = stat_upd_q + 32'd1;
            stat_mis_d = stat_mis_q + 32'(up_mispredict);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            ghr_q      <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ghr_q      <= ghr_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    // Tables carry no reset; the INIT sweep clears them.
    always_ff @(posedge clk) begin
        if (!rst && bht_we) bht_q[bht_waddr] <= bht_wdata;
        if (!rst && btb_we) begin
            btb_vld_q[btb_waddr] <= !init_busy;
            btb_tag_q[btb_waddr] <= up_pc[XLEN-1:INDEX_BITS];
            btb_tgt_q[btb_waddr] <= up_target;
        end
    end

    assign stat_updates = stat_upd_q;
    assign stat_mispred = stat_mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare (GHR_BITS=4) predictor driven from shared stimulus.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lk_pc, up_pc, up_target;
    logic        up_valid, up_taken, up_mispredict;
    logic [0:0]  up_ghr_b;
    logic [3:0]  up_ghr_g;

    logic        busy_b, pt_b, busy_g, pt_g;
    logic [31:0] ptgt_b, su_b, sm_b, ptgt_g, su_g, sm_g;
    logic [0:0]  ghr_b;
    logic [3:0]  ghr_g;

    int n_chk = 0;
    int n_fail = 0;
    int exp_upd = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_predictor u_bim (
        .clk(clk), .rst(rst), .init_busy(busy_b), .lk_pc(lk_pc), .pred_taken(pt_b),
        .pred_target(ptgt_b), .lk_ghr(ghr_b), .up_valid(up_valid), .up_pc(up_pc),
        .up_taken(up_taken), .up_target(up_target), .up_ghr(up_ghr_b),
        .up_mispredict(up_mispredict), .stat_updates(su_b), .stat_mispred(sm_b)
    );

    branch_predictor #(.GHR_BITS(4)) u_gsh (
        .clk(clk), .rst(rst), .init_busy(busy_g), .lk_pc(lk_pc), .pred_taken(pt_g),
        .pred_target(ptgt_g), .lk_ghr(ghr_g), .up_valid(up_valid), .up_pc(up_pc),
        .up_taken(up_taken), .up_target(up_target), .up_ghr(up_ghr_g),
        .up_mispredict(up_mispredict), .stat_updates(su_g), .stat_mispred(sm_g)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        lk_pc = pc;
        #2;
        chk({name, "_taken"}, 64'(pt_b), 64'(t));
        chk({name, "_target"}, 64'(ptgt_b), 64'(tgt));
    endtask

    task automatic look_g(input string name, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        lk_pc = pc;
        #2;
        chk({name, "_taken"}, 64'(pt_g), 64'(t));
        chk({name, "_target"}, 64'(ptgt_g), 64'(tgt));
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic [3:0] gh, input logic mis);
        up_valid = 1'b1; up_pc = pc; up_taken = t; up_target = tgt;
        up_ghr_g = gh; up_mispredict = mis;
        tick();
        up_valid = 1'b0;
        exp_upd++;
        if (mis) exp_mis++;
    endtask

    task automatic init_sweep(input string name);
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 255) begin
                chk({name, "_busy255"}, 64'(busy_b), 64'd1);
                chk({name, "_busy255_g"}, 64'(busy_g), 64'd1);
            end
            if (i == 256) begin
                chk({name, "_busy256"}, 64'(busy_b), 64'd0);
                chk({name, "_busy256_g"}, 64'(busy_g), 64'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'h140, 1'b1, 32'h200};
        vecs[1] = '{32'h040, 1'b0, 32'h041};
        vecs[2] = '{32'h007, 1'b0, 32'h008};
        vecs[3] = '{32'h009, 1'b1, 32'h300};
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[5] = '{32'h123, 1'b0, 32'h124};

        rst = 1'b1; lk_pc = 32'h40; up_valid = 1'b0; up_pc = '0; up_taken = 1'b0;
        up_target = '0; up_mispredict = 1'b0; up_ghr_b = '0; up_ghr_g = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy_b), 64'd1);
        chk("rst_stat_upd", 64'(su_b), 64'd0);

        // Updates offered during INIT must be dropped.
        rst = 1'b0;
        up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h99; up_mispredict = 1'b1;
        init_sweep("init");
        up_valid = 1'b0;
        chk("init_ignored_upd", 64'(su_b), 64'd0);
        chk("init_ignored_mis", 64'(sm_b), 64'd0);

        look("t1", 32'h40, 1'b0, 32'h41);
        chk("t1_ghr", 64'(ghr_b), 64'd0);

        // Same-cycle lookup and update on one entry sees the old value.
        up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h10; up_mispredict = 1'b1;
        lk_pc = 32'h40;
        #2;
        chk("same_cycle_taken", 64'(pt_b), 64'd0);
        chk("same_cycle_target", 64'(ptgt_b), 64'h41);
        tick();
        up_valid = 1'b0; exp_upd++; exp_mis++;
        look("t2_a", 32'h40, 1'b1, 32'h10);
        upd(32'h40, 1'b1, 32'h10, 4'h0, 1'b0);
        look("t2_b", 32'h40, 1'b1, 32'h10);
        upd(32'h40, 1'b0, 32'h0, 4'h0, 1'b1);
        look("t2_c", 32'h40, 1'b1, 32'h10);
        upd(32'h40, 1'b0, 32'h0, 4'h0, 1'b0);
        look("t2_d", 32'h40, 1'b0, 32'h41);

        repeat (5) upd(32'h7, 1'b1, 32'h123, 4'h0, 1'b0);
        upd(32'h7, 1'b0, 32'h0, 4'h0, 1'b1);
        look("sat_hi", 32'h7, 1'b1, 32'h123);
        upd(32'h7, 1'b0, 32'h0, 4'h0, 1'b0);
        look("sat_hi_nt", 32'h7, 1'b0, 32'h8);

        repeat (2) upd(32'h9, 1'b0, 32'h0, 4'h0, 1'b0);
        upd(32'h9, 1'b1, 32'h300, 4'h0, 1'b1);
        look("sat_lo_a", 32'h9, 1'b0, 32'hA);
        upd(32'h9, 1'b1, 32'h300, 4'h0, 1'b0);
        look("sat_lo_b", 32'h9, 1'b1, 32'h300);
        chk("stat_upd", 64'(su_b), 64'(exp_upd));
        chk("stat_mis", 64'(sm_b), 64'(exp_mis));

        upd(32'h140, 1'b1, 32'h200, 4'h0, 1'b0);
        look("alias_miss", 32'h40, 1'b0, 32'h41);
        look("alias_hit", 32'h140, 1'b1, 32'h200);

        for (int i = 0; i < 6; i++) look($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].tgt);
        chk("stat_upd2", 64'(su_b), 64'(exp_upd));

        // Reset mid-sweep restarts the full clear.
        rst = 1'b1;
        tick();
        chk("rst2_busy", 64'(busy_b), 64'd1);
        chk("rst2_stat_upd", 64'(su_b), 64'd0);
        chk("rst2_stat_mis", 64'(sm_b), 64'd0);
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_sweep("reinit");
        exp_upd = 0; exp_mis = 0;
        look("post_rst_a", 32'h140, 1'b0, 32'h141);
        look("post_rst_b", 32'h7, 1'b0, 32'h8);
        chk("post_rst_ghr_g", 64'(ghr_g), 64'd0);

        // gshare: same PC under different histories trains different BHT entries.
        repeat (2) upd(32'h20, 1'b1, 32'h55, 4'hF, 1'b0);
        chk("g_ghr_3", 64'(ghr_g), 64'h3);
        repeat (2) upd(32'h20, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("g_ghr_c", 64'(ghr_g), 64'hC);
        look_g("g_ghr_c_look", 32'h20, 1'b0, 32'h21);
        repeat (4) upd(32'h80, 1'b1, 32'h90, 4'h0, 1'b0);
        chk("g_ghr_f", 64'(ghr_g), 64'hF);
        look_g("g_hist_f", 32'h20, 1'b1, 32'h55);
        repeat (4) upd(32'h80, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("g_ghr_0", 64'(ghr_g), 64'h0);
        look_g("g_hist_0", 32'h20, 1'b0, 32'h21);
        chk("g_stat_upd", 64'(su_g), 64'(exp_upd));
        chk("bim_ghr_const", 64'(ghr_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
